// File: rtl/ide_pkg.sv
// rtl/ide_pkg.sv - shared constants, status layout and FSM state type for the IDE target
package ide_pkg;

  // CS1 task-file addresses; DATA..STATUS also name the write-side registers at the same DA
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_ERROR   = 3'd1;
  localparam logic [2:0] REG_SECCNT  = 3'd2;
  localparam logic [2:0] REG_LBA_LO  = 3'd3;
  localparam logic [2:0] REG_LBA_MID = 3'd4;
  localparam logic [2:0] REG_LBA_HI  = 3'd5;
  localparam logic [2:0] REG_DEVICE  = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;
  // CS2 control block: alt-status on read, device control on write
  localparam logic [2:0] REG_ALTSTAT = 3'd6;

  localparam int ST_BSY  = 7;
  localparam int ST_DRDY = 6;
  localparam int ST_DRQ  = 3;
  localparam int ST_ERR  = 0;

  localparam int DEVCTL_NIEN = 1;
  localparam int DEVCTL_SRST = 2;

  localparam logic [7:0] CMD_READ_SECTORS  = 8'h20;
  localparam logic [7:0] CMD_WRITE_SECTORS = 8'h30;
  localparam logic [7:0] ERR_ABRT          = 8'h04;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_DRQ_WR = 2'd2,
    S_DRQ_RD = 2'd3
  } ide_state_e;

  function automatic logic [7:0] pack_status(input logic bsy, input logic drdy,
                                             input logic drq, input logic err);
    logic [7:0] s;
    s          = 8'h00;
    s[ST_BSY]  = bsy;
    s[ST_DRDY] = drdy;
    s[ST_DRQ]  = drq;
    s[ST_ERR]  = err;
    return s;
  endfunction

endpackage

// File: rtl/ide_sector_buf.sv
// rtl/ide_sector_buf.sv - 256x16 sector buffer, synchronous write, asynchronous read
module ide_sector_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ide_target.sv
// rtl/ide_target.sv - IDE PIO target: synchronized host bus, task file, sector FSM
// Interrupt output is only live when IDE_TARGET_IRQ_EN is defined.
module ide_target
  import ide_pkg::*;
#(
  parameter int BUSY_CYCLES = 16,
  parameter int IORDY_WAIT  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IDECS1_n,
  input  logic        IDECS2_n,
  input  logic [2:0]  DA,
  input  logic        IOR_n,
  input  logic        IOW_n,
  input  logic [15:0] DD_IN,
  output logic [15:0] DD_OUT,
  output logic        DD_OE,
  output logic        IORDY,
  output logic        INTRQ
);

  localparam logic [15:0] BUSY_LOAD  = 16'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);
  localparam logic [7:0]  IORDY_LOAD = 8'(IORDY_WAIT);

  // bit order {IOW_n, IOR_n, IDECS2_n, IDECS1_n}
  logic [3:0]  meta_q, meta_d, sync_q, sync_d;
  logic [1:0]  prev_q, prev_d;

  ide_state_e  state_q, state_d;
  logic        xfer_rd_q, xfer_rd_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]  iordy_cnt_q, iordy_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  error_q, error_d;
  logic [7:0]  features_q, features_d;
  logic [7:0]  seccnt_q, seccnt_d;
  logic [7:0]  lba_lo_q, lba_lo_d;
  logic [7:0]  lba_mid_q, lba_mid_d;
  logic [7:0]  lba_hi_q, lba_hi_d;
  logic [7:0]  device_q, device_d;
  logic        srst_q, srst_d;
  logic        nien_q, nien_d;
  logic        intrq_q, intrq_d;

  logic        cs1_sel, cs2_sel, selected;
  logic        ior_fall, ior_rise, iow_fall, iow_rise;
  logic        wr_cs1, rd_cs1;
  logic        buf_we, advance, intrq_set, intrq_clr;
  logic [15:0] buf_rdata;
  logic [7:0]  status;
  logic        unused_regs;

  always_comb begin
    meta_d = {IOW_n, IOR_n, IDECS2_n, IDECS1_n};
    sync_d = meta_q;
    prev_d = sync_q[3:2];
  end

  assign cs1_sel  = ~sync_q[0];
  assign cs2_sel  = ~sync_q[1];
  assign selected = cs1_sel | cs2_sel;
  assign ior_fall = prev_q[0] & ~sync_q[2];
  assign ior_rise = ~prev_q[0] & sync_q[2];
  assign iow_fall = prev_q[1] & ~sync_q[3];
  assign iow_rise = ~prev_q[1] & sync_q[3];
  assign wr_cs1   = iow_rise & cs1_sel;
  assign rd_cs1   = ior_rise & cs1_sel;

  assign status = pack_status(state_q == S_BUSY, state_q != S_BUSY,
                              (state_q == S_DRQ_WR) || (state_q == S_DRQ_RD), err_q);

  ide_sector_buf u_buf (
    .clk   (CLK),
    .we    (buf_we),
    .waddr (ptr_q),
    .wdata (DD_IN),
    .raddr (ptr_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    xfer_rd_d   = xfer_rd_q;
    ptr_d       = ptr_q;
    busy_cnt_d  = busy_cnt_q;
    iordy_cnt_d = iordy_cnt_q;
    err_d       = err_q;
    error_d     = error_q;
    features_d  = features_q;
    seccnt_d    = seccnt_q;
    lba_lo_d    = lba_lo_q;
    lba_mid_d   = lba_mid_q;
    lba_hi_d    = lba_hi_q;
    device_d    = device_q;
    srst_d      = srst_q;
    nien_d      = nien_q;
    buf_we      = 1'b0;
    advance     = 1'b0;
    intrq_set   = 1'b0;
    intrq_clr   = 1'b0;

    if (iordy_cnt_q != 8'd0) begin
      iordy_cnt_d = iordy_cnt_q - 8'd1;
    end
    if ((ior_fall | iow_fall) & selected) begin
      iordy_cnt_d = IORDY_LOAD;
    end

    if (iow_rise && cs2_sel && (DA == REG_ALTSTAT)) begin
      srst_d = DD_IN[DEVCTL_SRST];
      nien_d = DD_IN[DEVCTL_NIEN];
    end

    if (state_q == S_BUSY) begin
      if (busy_cnt_q == 16'd0) begin
        state_d = xfer_rd_q ? S_DRQ_RD : S_DRQ_WR;
      end else begin
        busy_cnt_d = busy_cnt_q - 16'd1;
      end
    end

    if (wr_cs1) begin
      case (DA)
        REG_DATA: begin
          if (state_q == S_DRQ_WR) begin
            buf_we  = 1'b1;
            advance = 1'b1;
          end
        end
        REG_ERROR:   features_d = DD_IN[7:0];
        REG_SECCNT:  seccnt_d   = DD_IN[7:0];
        REG_LBA_LO:  lba_lo_d   = DD_IN[7:0];
        REG_LBA_MID: lba_mid_d  = DD_IN[7:0];
        REG_LBA_HI:  lba_hi_d   = DD_IN[7:0];
        REG_DEVICE:  device_d   = DD_IN[7:0];
        REG_STATUS: begin
          if (state_q == S_IDLE) begin
            if ((DD_IN[7:0] == CMD_READ_SECTORS) || (DD_IN[7:0] == CMD_WRITE_SECTORS)) begin
              err_d      = 1'b0;
              ptr_d      = 8'd0;
              xfer_rd_d  = (DD_IN[7:0] == CMD_READ_SECTORS);
              busy_cnt_d = BUSY_LOAD;
              if (BUSY_CYCLES == 0) begin
                state_d = (DD_IN[7:0] == CMD_READ_SECTORS) ? S_DRQ_RD : S_DRQ_WR;
              end else begin
                state_d = S_BUSY;
              end
            end else begin
              err_d     = 1'b1;
              error_d   = ERR_ABRT;
              intrq_set = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (rd_cs1 && (DA == REG_DATA) && (state_q == S_DRQ_RD)) begin
      advance = 1'b1;
    end
    if (rd_cs1 && (DA == REG_STATUS)) begin
      intrq_clr = 1'b1;
    end

    // sector count 0 wraps to 255 here, which is what makes it mean 256 sectors
    if (advance) begin
      ptr_d = ptr_q + 8'd1;
      if (ptr_q == 8'hFF) begin
        seccnt_d = seccnt_q - 8'd1;
        if (seccnt_q == 8'd1) begin
          state_d   = S_IDLE;
          intrq_set = 1'b1;
        end else begin
          busy_cnt_d = BUSY_LOAD;
          state_d    = (BUSY_CYCLES == 0) ? state_q : S_BUSY;
        end
      end
    end

    intrq_d = (intrq_q & ~intrq_clr) | intrq_set;

    // soft reset holds the task file in its reset state; device control itself is kept
    if (srst_q) begin
      state_d    = S_IDLE;
      xfer_rd_d  = 1'b0;
      ptr_d      = 8'd0;
      busy_cnt_d = 16'd0;
      err_d      = 1'b0;
      error_d    = 8'h01;
      features_d = 8'h00;
      seccnt_d   = 8'h01;
      lba_lo_d   = 8'h00;
      lba_mid_d  = 8'h00;
      lba_hi_d   = 8'h00;
      device_d   = 8'h00;
      intrq_d    = 1'b0;
      buf_we     = 1'b0;
    end
  end

  always_comb begin
    DD_OUT = 16'h0000;
    if (cs1_sel) begin
      case (DA)
        REG_DATA:    DD_OUT = (state_q == S_DRQ_RD) ? buf_rdata : 16'h0000;
        REG_ERROR:   DD_OUT = {8'h00, error_q};
        REG_SECCNT:  DD_OUT = {8'h00, seccnt_q};
        REG_LBA_LO:  DD_OUT = {8'h00, lba_lo_q};
        REG_LBA_MID: DD_OUT = {8'h00, lba_mid_q};
        REG_LBA_HI:  DD_OUT = {8'h00, lba_hi_q};
        REG_DEVICE:  DD_OUT = {8'h00, device_q};
        REG_STATUS:  DD_OUT = {8'h00, status};
        default:     DD_OUT = 16'h0000;
      endcase
    end else if (cs2_sel && (DA == REG_ALTSTAT)) begin
      DD_OUT = {8'h00, status};
    end
  end

  assign DD_OE = selected & ~sync_q[2];
  assign IORDY = (iordy_cnt_q == 8'd0);

`ifdef IDE_TARGET_IRQ_EN
  assign INTRQ       = intrq_q & ~nien_q;
  assign unused_regs = ^features_q;
`else
  assign INTRQ       = 1'b0;
  assign unused_regs = ^{features_q, nien_q, intrq_q};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q      <= 4'hF;
      sync_q      <= 4'hF;
      prev_q      <= 2'b11;
      state_q     <= S_IDLE;
      xfer_rd_q   <= 1'b0;
      ptr_q       <= 8'd0;
      busy_cnt_q  <= 16'd0;
      iordy_cnt_q <= 8'd0;
      err_q       <= 1'b0;
      error_q     <= 8'h01;
      features_q  <= 8'h00;
      seccnt_q    <= 8'h01;
      lba_lo_q    <= 8'h00;
      lba_mid_q   <= 8'h00;
      lba_hi_q    <= 8'h00;
      device_q    <= 8'h00;
      srst_q      <= 1'b0;
      nien_q      <= 1'b0;
      intrq_q     <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      xfer_rd_q   <= xfer_rd_d;
      ptr_q       <= ptr_d;
      busy_cnt_q  <= busy_cnt_d;
      iordy_cnt_q <= iordy_cnt_d;
      err_q       <= err_d;
      error_q     <= error_d;
      features_q  <= features_d;
      seccnt_q    <= seccnt_d;
      lba_lo_q    <= lba_lo_d;
      lba_mid_q   <= lba_mid_d;
      lba_hi_q    <= lba_hi_d;
      device_q    <= device_d;
      srst_q      <= srst_d;
      nien_q      <= nien_d;
      intrq_q     <= intrq_d;
    end
  end

endmodule

// File: tb/tb_ide_target.sv
// tb/tb_ide_target.sv - directed/random bench for ide_target against a transaction-level model
module tb_ide_target;

  localparam int BUSY_CYC  = 16;
  localparam int IORDY_CYC = 4;
`ifdef IDE_TARGET_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cs1_n, cs2_n, ior_n, iow_n;
  logic [2:0]  da;
  logic [15:0] dd_in, dd_out;
  logic        dd_oe, iordy, intrq;

  ide_target #(.BUSY_CYCLES(BUSY_CYC), .IORDY_WAIT(IORDY_CYC)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .IDECS1_n (cs1_n),
    .IDECS2_n (cs2_n),
    .DA       (da),
    .IOR_n    (ior_n),
    .IOW_n    (iow_n),
    .DD_IN    (dd_in),
    .DD_OUT   (dd_out),
    .DD_OE    (dd_oe),
    .IORDY    (iordy),
    .INTRQ    (intrq)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model: buffer contents, readable task-file bytes by DA, and transfer bookkeeping
  logic [15:0] m_buf [256];
  logic [7:0]  m_tf [8];
  bit          m_err, m_irq, m_active, m_rd;
  int          m_ptr, m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_tf[i] = 8'h00;
    m_tf[1] = 8'h01;
    m_tf[2] = 8'h01;
    m_err = 0; m_irq = 0; m_active = 0; m_rd = 0; m_ptr = 0; m_left = 0;
  endtask

  function automatic logic [7:0] m_status();
    if (m_active) return 8'h48;
    return m_err ? 8'h41 : 8'h40;
  endfunction

  task automatic m_step();
    m_ptr++;
    if (m_ptr == 256) begin
      m_ptr = 0;
      m_left--;
      m_tf[2] = 8'(m_left);
      if (m_left == 0) begin
        m_active = 0;
        m_irq    = 1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input bit sel2, input logic [2:0] a, input logic [15:0] d);
    cs1_n = sel2; cs2_n = !sel2; da = a; dd_in = d;
    tick(1);
    iow_n = 0; tick(3);
    iow_n = 1; tick(4);
    cs1_n = 1; cs2_n = 1;
    tick(1);
  endtask

  task automatic bus_read(input bit sel2, input logic [2:0] a, output logic [15:0] d);
    cs1_n = sel2; cs2_n = !sel2; da = a;
    tick(1);
    ior_n = 0; tick(3);
    d = dd_out;
    check("dd_oe_during_read", 32'(dd_oe), 32'd1);
    ior_n = 1; tick(4);
    cs1_n = 1; cs2_n = 1;
    tick(1);
  endtask

  task automatic tf_write(input logic [2:0] a, input logic [7:0] v);
    bus_write(0, a, {8'($urandom), v});
    if (a >= 3'd2 && a <= 3'd6) m_tf[a] = v;
  endtask

  task automatic reg_check(input string tag, input bit sel2, input logic [2:0] a);
    logic [15:0] d, exp;
    exp = (sel2 || a == 3'd7) ? {8'h00, m_status()} : {8'h00, m_tf[a]};
    bus_read(sel2, a, d);
    check(tag, 32'(d), 32'(exp));
    if (!sel2 && a == 3'd7) m_irq = 0;
  endtask

  task automatic check_intrq(input string tag);
    check(tag, 32'(intrq), (IRQ_EN && m_irq) ? 32'd1 : 32'd0);
  endtask

  task automatic data_write(input logic [15:0] w);
    bus_write(0, 3'd0, w);
    if (m_active && !m_rd) begin
      m_buf[m_ptr] = w;
      m_step();
    end
  endtask

  task automatic data_read_check(input string tag);
    logic [15:0] d, exp;
    exp = (m_active && m_rd) ? m_buf[m_ptr] : 16'h0000;
    bus_read(0, 3'd0, d);
    check(tag, 32'(d), 32'(exp));
    if (m_active && m_rd) m_step();
  endtask

  // issues a command and counts how many cycles BSY is visible on the status register
  task automatic do_cmd(input logic [7:0] code);
    int busy_n = 0;
    bit accept;
    accept = !m_active && (code == 8'h20 || code == 8'h30);
    cs1_n = 0; cs2_n = 1; da = 3'd7; dd_in = {8'($urandom), code};
    tick(1);
    iow_n = 0; tick(3);
    iow_n = 1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (dd_out[7]) busy_n++;
    end
    cs1_n = 1;
    tick(1);
    check("cmd_busy_cycles", 32'(busy_n), accept ? 32'(BUSY_CYC) : 32'd0);
    if (!m_active) begin
      if (accept) begin
        m_err = 0; m_rd = (code == 8'h20); m_ptr = 0; m_active = 1;
        m_left = (m_tf[2] == 8'h00) ? 256 : int'(m_tf[2]);
      end else begin
        m_err = 1; m_tf[1] = 8'h04; m_irq = 1;
      end
    end
  endtask

  task automatic wait_ready();
    bit ok = 0;
    cs1_n = 0; cs2_n = 1; da = 3'd7;
    tick(3);
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (!dd_out[7]) ok = 1;
    end
    cs1_n = 1;
    tick(1);
    check("wait_ready_bound", 32'(ok), 32'd1);
  endtask

  // mode 0: selected read, 1: selected write, 2: write with no chip select
  task automatic iordy_probe(input string tag, input int mode, input int exp);
    int lows = 0;
    cs1_n = (mode == 2); cs2_n = 1;
    da = (mode == 0) ? 3'd3 : 3'd4;
    dd_in = {8'h00, m_tf[4]};
    tick(2);
    if (mode == 0) ior_n = 0; else iow_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (!iordy) lows++;
    end
    ior_n = 1; iow_n = 1; tick(4);
    cs1_n = 1;
    tick(1);
    check(tag, 32'(lows), 32'(exp));
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  code;
    reset = 1; cs1_n = 1; cs2_n = 1; da = 3'd0; ior_n = 1; iow_n = 1; dd_in = 16'h0;
    m_reset();
    tick(4);
    reset = 0;
    tick(2);

    check("rst_iordy", 32'(iordy), 32'd1);
    check("rst_dd_oe", 32'(dd_oe), 32'd0);
    check_intrq("rst_intrq");
    reg_check("rst_status", 0, 3'd7);
    reg_check("rst_error", 0, 3'd1);
    reg_check("rst_seccnt", 0, 3'd2);
    for (int a = 3; a <= 6; a++) reg_check("rst_taskfile", 0, 3'(a));
    reg_check("rst_altstatus", 1, 3'd6);
    data_read_check("idle_data_read");

    repeat (3) begin
      for (int a = 2; a <= 6; a++) tf_write(3'(a), 8'($urandom));
      for (int a = 2; a <= 6; a++) reg_check("taskfile_readback", 0, 3'(a));
    end
    data_write(16'hBEEF);
    data_read_check("idle_data_write_ignored");

    iordy_probe("iordy_read_low", 0, IORDY_CYC);
    iordy_probe("iordy_write_low", 1, IORDY_CYC);
    iordy_probe("iordy_unselected", 2, 0);

    do_cmd(8'hEC);
    check_intrq("abrt_intrq");
    reg_check("abrt_altstatus", 1, 3'd6);
    check_intrq("abrt_intrq_after_alt");
    reg_check("abrt_error", 0, 3'd1);
    reg_check("abrt_status", 0, 3'd7);
    check_intrq("abrt_intrq_cleared");
    repeat (3) begin
      do code = 8'($urandom); while (code == 8'h20 || code == 8'h30);
      do_cmd(code);
      reg_check("rand_abrt_error", 0, 3'd1);
      check_intrq("rand_abrt_intrq");
      reg_check("rand_abrt_status", 0, 3'd7);
    end

    tf_write(3'd2, 8'h01);
    do_cmd(8'h30);
    reg_check("wr_drq_status", 0, 3'd7);
    for (int i = 0; i < 256; i++) data_write(16'(i));
    check_intrq("wr_done_intrq");
    reg_check("wr_done_status", 0, 3'd7);
    check_intrq("wr_done_intrq_cleared");

    tf_write(3'd2, 8'h01);
    do_cmd(8'h20);
    reg_check("rd_drq_status", 0, 3'd7);
    for (int i = 0; i < 256; i++) begin
      data_read_check("rd_ramp_word");
      if (i == 100) begin
        do_cmd(8'hEC);
        reg_check("cmd_ignored_status", 0, 3'd7);
      end
    end
    check_intrq("rd_done_intrq");
    reg_check("rd_done_altstatus", 1, 3'd6);
    reg_check("rd_done_status", 0, 3'd7);
    check_intrq("rd_done_intrq_cleared");

    tf_write(3'd2, 8'h02);
    do_cmd(8'h30);
    for (int i = 0; i < 256; i++) data_write(16'($urandom));
    bus_read(0, 3'd7, d);
    check("sector_gap_busy", 32'(d), 32'h80);
    wait_ready();
    reg_check("sector2_drq_status", 0, 3'd7);
    reg_check("sector2_seccnt", 0, 3'd2);
    for (int i = 0; i < 256; i++) data_write(16'($urandom));
    reg_check("two_sector_seccnt", 0, 3'd2);
    check_intrq("two_sector_intrq");
    reg_check("two_sector_status", 0, 3'd7);
    tf_write(3'd2, 8'h01);
    do_cmd(8'h20);
    for (int i = 0; i < 256; i++) data_read_check("rd_random_word");
    reg_check("rd_random_done_status", 0, 3'd7);

    tf_write(3'd3, 8'h5A);
    tf_write(3'd2, 8'h00);
    do_cmd(8'h30);
    for (int i = 0; i < 256; i++) data_write(16'($urandom));
    bus_read(0, 3'd7, d);
    check("seccnt0_gap_busy", 32'(d), 32'h80);
    wait_ready();
    reg_check("seccnt0_remaining", 0, 3'd2);
    for (int i = 0; i < 5; i++) data_write(16'($urandom));
    bus_write(1, 3'd6, 16'h0004);
    m_reset();
    reg_check("srst_held_status", 0, 3'd7);
    bus_write(1, 3'd6, 16'h0000);
    reg_check("srst_status", 0, 3'd7);
    reg_check("srst_error", 0, 3'd1);
    reg_check("srst_seccnt", 0, 3'd2);
    reg_check("srst_lba_lo", 0, 3'd3);
    check_intrq("srst_intrq");
    data_read_check("srst_idle_data");
    do_cmd(8'h20);
    for (int i = 0; i < 256; i++) data_read_check("post_srst_word");
    reg_check("post_srst_done_status", 0, 3'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ide_target.md
IDE_TARGET -- requirements
Module: ide_target

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 16, CLK cycles BSY stays set after command accept or sector end.
REQ-002 SHALL have parameter IORDY_WAIT, default 2, CLK cycles IORDY held low after a strobe falling edge.
REQ-003 SHALL have port CLK, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports IDECS1_n and IDECS2_n, input, 1 each, active-low task-file and control-block selects.
REQ-006 SHALL have port DA, input, 3, register address.
REQ-007 SHALL have ports IOR_n and IOW_n, input, 1 each, active-low read and write strobes.
REQ-008 SHALL have port DD_IN, input, 16, host write data.
REQ-009 SHALL have port DD_OUT, output, 16, read data.
REQ-010 SHALL have port DD_OE, output, 1, high while a selected read strobe is active.
REQ-011 SHALL have port IORDY, output, 1, device ready.
REQ-012 SHALL have port INTRQ, output, 1, active-high interrupt request.

Function
REQ-013 SHALL pass IDECS1_n, IDECS2_n, IOR_n and IOW_n through 2-flop synchronizers; all edge detection SHALL use the synchronized copies.
REQ-014 SHALL implement CS1 registers: DA0 data (16-bit), DA1 error (R) / features (W), DA2 sector count, DA3-5 LBA low/mid/high, DA6 device, DA7 status (R) / command (W); CS2 DA6: alt-status (R) / device control (W). All other registers are 8-bit on DD[7:0], with DD[15:8] reading 0x00.
REQ-015 SHALL latch register writes from DD_IN on the synchronized IOW_n rising edge while the matching CS is asserted.
REQ-016 SHALL drive DD_OUT combinationally from the addressed register; DD_OE = selected && !IOR_n (synchronized).
REQ-017 SHALL drive IORDY low for IORDY_WAIT cycles from each synchronized IOR_n/IOW_n falling edge while selected; IORDY_WAIT=0 holds IORDY high.
REQ-018 SHALL place status bits BSY=7, DRDY=6, DRQ=3, ERR=0; all other bits read 0.
REQ-019 SHALL implement FSM states IDLE, BUSY, DRQ_WR, DRQ_RD.
REQ-020 IDLE: command 0x30 -> BUSY then DRQ_WR; 0x20 -> BUSY then DRQ_RD; any other code -> stay IDLE, ERR=1, error=0x04 (ABRT), INTRQ set.
REQ-021 BUSY SHALL last exactly BUSY_CYCLES cycles with BSY=1, DRQ=0, DRDY=0.
REQ-022 DRQ_WR: each data write stores one word at the 8-bit buffer pointer, then increments it; DRQ_RD: data register reads the word at the pointer, which increments on the IOR_n rising edge.
REQ-023 Pointer wrap 255->0 SHALL end the sector: sector count decrements; nonzero -> BUSY -> same DRQ state; zero -> IDLE, INTRQ set. Sector count 0 at command accept SHALL mean 256 sectors.
REQ-024 Any command write while not IDLE SHALL be ignored.
REQ-025 Data register accesses outside DRQ states SHALL read 0x0000 and ignore writes.
REQ-026 A status (CS1 DA7) read SHALL clear INTRQ on its rising edge; an alt-status read SHALL not.
REQ-027 A new INTRQ set in the same cycle as a status-read clear SHALL win.
REQ-028 ERR SHALL clear on acceptance of the next valid command.

Reset
REQ-029 On RESET: FSM IDLE, pointer 0, status 0x40, error 0x01, sector count 0x01, LBA/device/features 0x00, INTRQ 0, IORDY 1, DD_OE 0; buffer contents undefined.
REQ-030 Device control bit 2 (SRST) written 1 SHALL apply REQ-029 state, except device control, and hold it until written 0; this overrides a transfer in progress.

Configuration
REQ-031 With IDE_TARGET_IRQ_EN defined: INTRQ per REQ-020/023/026/027, gated low while device control bit 1 (nIEN) = 1. Undefined: INTRQ is constant 0, and nIEN is stored but has no effect.

Structure
REQ-032 Shared package ide_pkg SHALL hold register address constants, status bit indices, command codes (0x20, 0x30) and the FSM state enum.
REQ-033 The 256x16 buffer SHALL be sub-module ide_sector_buf: one synchronous write port and one asynchronous read port.

Verification
REQ-034 Write 0x01 to sector count, then 0x30 to the command register -> BSY for 16 cycles, then status 0x48.
REQ-035 Write 256 words 0x0000..0x00FF, then issue 0x20 -> 256 reads return 0x0000..0x00FF; status 0x40; INTRQ 1 until status is read.
REQ-036 Command 0xEC -> status 0x41, error 0x04, INTRQ 1; an alt-status read leaves INTRQ 1.
REQ-037 Sector count 2 with command 0x30 -> BSY after word 256, DRQ again, status 0x40 after word 512.
REQ-038 SRST asserted mid-DRQ_WR -> status 0x40, pointer 0; a subsequent 0x20 reads from word 0.
REQ-039 IORDY_WAIT=4 -> IORDY low exactly 4 cycles after each synchronized strobe falling edge.
